// File: rtl/alu_writeback_stage_pkg.sv
// Shared widths, flag bit positions and the buffered result payload for the ALU writeback stage.
package alu_writeback_stage_pkg;

   localparam int unsigned WORD_SIZE  = 19;
   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned FLAG_W     = 4;

   localparam int unsigned ZERO_FLAG     = 0;
   localparam int unsigned SIGN_FLAG     = 1;
   localparam int unsigned CARRY_FLAG    = 2;
   localparam int unsigned OVERFLOW_FLAG = 3;

   typedef struct packed {
      logic [WORD_SIZE-1:0]  result;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wr_en;
      logic                  flags_en;
      logic                  mode;
      logic                  carry;
      logic                  overflow;
   } wb_entry_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_TWO   = 2'd2
   } fifo_state_t;

   // Logical ops never report carry/overflow, whatever the unit drove.
   function automatic logic [FLAG_W-1:0] entry_flags(input wb_entry_t e);
      logic [FLAG_W-1:0] f;
      f                = '0;
      f[ZERO_FLAG]     = (e.result == '0);
      f[SIGN_FLAG]     = e.result[WORD_SIZE-1];
      f[CARRY_FLAG]    = ~e.mode & e.carry;
      f[OVERFLOW_FLAG] = ~e.mode & e.overflow;
      return f;
   endfunction

endpackage

// File: rtl/alu_writeback_stage_wb_skid_fifo.sv
// Two-entry skid FIFO of writeback entries; head is always entry 0, flush empties it synchronously.
module wb_skid_fifo
   import alu_writeback_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  wb_entry_t  push_entry,
   output wb_entry_t  head,
   output logic [1:0] count,
   output logic       full_c
);

   fifo_state_t state, state_nxt;
   wb_entry_t   head_q, head_nxt;
   wb_entry_t   tail_q, tail_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FIFO_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         state  <= state_nxt;
         head_q <= head_nxt;
         tail_q <= tail_nxt;
      end
   end

   // Next-state and entry movement; pushes while full and pops while empty are ignored.
   always_comb begin
      state_nxt = state;
      head_nxt  = head_q;
      tail_nxt  = tail_q;
      if (flush) begin
         state_nxt = FIFO_EMPTY;
         head_nxt  = '0;
         tail_nxt  = '0;
      end else begin
         case (state)
            FIFO_EMPTY: begin
               if (push) begin
                  head_nxt  = push_entry;
                  state_nxt = FIFO_ONE;
               end
            end
            FIFO_ONE: begin
               if (push && pop) begin
                  head_nxt = push_entry;
               end else if (push) begin
                  tail_nxt  = push_entry;
                  state_nxt = FIFO_TWO;
               end else if (pop) begin
                  head_nxt  = '0;
                  state_nxt = FIFO_EMPTY;
               end
            end
            FIFO_TWO: begin
               if (pop) begin
                  head_nxt  = tail_q;
                  tail_nxt  = '0;
                  state_nxt = FIFO_ONE;
               end
            end
            default: begin
               state_nxt = FIFO_EMPTY;
            end
         endcase
      end
   end

   assign head   = head_q;
   assign count  = state;
   assign full_c = (state == FIFO_TWO);

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: buffers results, commits them to the register file, updates FLAGS, forwards the head.
module alu_writeback_stage
   import alu_writeback_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_SIZE-1:0]  in_result,
   input  logic                  in_carry,
   input  logic                  in_overflow,
   input  logic                  in_mode,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic                  in_wr_en,
   input  logic                  in_flags_en,
   input  logic                  rf_busy,
   input  logic                  flush,
   output logic                  rf_wr_en,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [WORD_SIZE-1:0]  rf_wr_data,
   output logic [FLAG_W-1:0]     flags,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_addr,
   output logic [WORD_SIZE-1:0]  fwd_data
);

   wb_entry_t  in_entry;
   wb_entry_t  head;
   logic [1:0] count;
   logic       full_c;
   logic       occupied;
   logic       push;
   logic       commit;

   assign in_entry = '{result:   in_result,
                       dest:     in_dest,
                       wr_en:    in_wr_en,
                       flags_en: in_flags_en,
                       mode:     in_mode,
                       carry:    in_carry,
                       overflow: in_overflow};

   assign in_ready = ~full_c;
   assign push     = in_valid & in_ready;
   assign occupied = (count != 2'd0);
   // Flush wins over commit; a busy write port simply holds the head.
   assign commit   = occupied & ~rf_busy & ~flush;

   wb_skid_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (commit),
      .flush      (flush),
      .push_entry (in_entry),
      .head       (head),
      .count      (count),
      .full_c     (full_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
      end else if (commit && head.flags_en) begin
         flags <= entry_flags(head);
      end
   end

   assign rf_wr_en   = commit & head.wr_en;
   assign rf_wr_addr = head.dest;
   assign rf_wr_data = head.result;

   assign fwd_valid  = occupied & head.wr_en;
   assign fwd_addr   = head.dest;
   assign fwd_data   = head.result;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: queue-based reference model, negedge monitor.
module tb_alu_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] in_result;
   logic        in_carry;
   logic        in_overflow;
   logic        in_mode;
   logic [2:0]  in_dest;
   logic        in_wr_en;
   logic        in_flags_en;
   logic        rf_busy;
   logic        flush;
   logic        rf_wr_en;
   logic [2:0]  rf_wr_addr;
   logic [18:0] rf_wr_data;
   logic [3:0]  flags;
   logic        fwd_valid;
   logic [2:0]  fwd_addr;
   logic [18:0] fwd_data;

   alu_writeback_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_carry    (in_carry),
      .in_overflow (in_overflow),
      .in_mode     (in_mode),
      .in_dest     (in_dest),
      .in_wr_en    (in_wr_en),
      .in_flags_en (in_flags_en),
      .rf_busy     (rf_busy),
      .flush       (flush),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .flags       (flags),
      .fwd_valid   (fwd_valid),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] result;
      logic [2:0]  dest;
      bit          wr_en;
      bit          flags_en;
      bit          mode;
      bit          carry;
      bit          ovf;
   } m_entry_t;

   typedef struct {
      bit          ready;
      bit          wr;
      bit          fv;
      logic [2:0]  fa;
      logic [18:0] fd;
      logic [3:0]  fl;
   } cyc_t;

   m_entry_t    mq[$];
   logic [21:0] exp_wr[$];
   cyc_t        cyc_q[$];
   logic [3:0]  mflags;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Flags as {overflow, carry, sign, zero}; sign read as "upper half of the unsigned range".
   function automatic logic [3:0] ref_flags(input m_entry_t e);
      bit z, s, c, o;
      z = (e.result == 19'd0);
      s = (e.result >= 19'h40000);
      c = e.mode ? 1'b0 : e.carry;
      o = e.mode ? 1'b0 : e.ovf;
      return {o, c, s, z};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // One clock of stimulus: drive inputs, record expected outputs, then advance the model.
   task automatic step(input bit v, input logic [18:0] res, input bit c, input bit o,
                       input bit m, input logic [2:0] d, input bit we, input bit fe,
                       input bit busy, input bit fl);
      m_entry_t e;
      m_entry_t h;
      cyc_t     r;
      bit       acc;
      @(posedge clk);
      #1;
      in_valid    = v;
      in_result   = res;
      in_carry    = c;
      in_overflow = o;
      in_mode     = m;
      in_dest     = d;
      in_wr_en    = we;
      in_flags_en = fe;
      rf_busy     = busy;
      flush       = fl;

      r.ready = (mq.size() < 2);
      r.wr    = 1'b0;
      r.fv    = 1'b0;
      r.fa    = 3'd0;
      r.fd    = 19'd0;
      r.fl    = mflags;
      if (mq.size() > 0) begin
         r.fv = mq[0].wr_en;
         r.fa = mq[0].dest;
         r.fd = mq[0].result;
         r.wr = mq[0].wr_en && !busy && !fl;
      end
      cyc_q.push_back(r);

      if (fl) begin
         foreach (mq[i]) if (mq[i].wr_en) void'(exp_wr.pop_back());
         mq.delete();
      end else begin
         acc = v && (mq.size() < 2);
         if (mq.size() > 0 && !busy) begin
            h = mq.pop_front();
            if (h.flags_en) mflags = ref_flags(h);
         end
         if (acc) begin
            e = '{result: res, dest: d, wr_en: we, flags_en: fe, mode: m, carry: c, ovf: o};
            mq.push_back(e);
            if (we) exp_wr.push_back({d, res});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 19'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
      chk({tag, "_rf_wr_en"},   32'(rf_wr_en),   32'd0);
      chk({tag, "_flags"},      32'(flags),      32'd0);
      chk({tag, "_fwd_valid"},  32'(fwd_valid),  32'd0);
      chk({tag, "_rf_wr_addr"}, 32'(rf_wr_addr), 32'd0);
      chk({tag, "_rf_wr_data"}, 32'(rf_wr_data), 32'd0);
      chk({tag, "_fwd_addr"},   32'(fwd_addr),   32'd0);
      chk({tag, "_fwd_data"},   32'(fwd_data),   32'd0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b1;
      #1;
      check_reset_outputs("midrst");
      mq.delete();
      exp_wr.delete();
      cyc_q.delete();
      mflags = 4'd0;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
   endtask

   // Monitor: per-cycle expectations plus an in-order write scoreboard.
   always @(negedge clk) begin
      cyc_t        r;
      logic [21:0] w;
      if (cyc_q.size() > 0) begin
         r = cyc_q.pop_front();
         chk("in_ready",  32'(in_ready),  32'(r.ready));
         chk("rf_wr_en",  32'(rf_wr_en),  32'(r.wr));
         chk("fwd_valid", 32'(fwd_valid), 32'(r.fv));
         if (r.fv) begin
            chk("fwd_addr", 32'(fwd_addr), 32'(r.fa));
            chk("fwd_data", 32'(fwd_data), 32'(r.fd));
         end
         chk("flags", 32'(flags), 32'(r.fl));
         if (rf_wr_en) begin
            if (exp_wr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rf_write: got write %0h<=%0h, required no write", rf_wr_addr, rf_wr_data);
            end else begin
               w = exp_wr.pop_front();
               chk("rf_wr_addr", 32'(rf_wr_addr), 32'(w[21:19]));
               chk("rf_wr_data", 32'(rf_wr_data), 32'(w[18:0]));
            end
         end
      end
   end

   initial begin
      logic [18:0] rres;
      rst = 1'b0; in_valid = 1'b0; in_result = 19'd0; in_carry = 1'b0; in_overflow = 1'b0;
      in_mode = 1'b0; in_dest = 3'd0; in_wr_en = 1'b0; in_flags_en = 1'b0;
      rf_busy = 1'b0; flush = 1'b0; mflags = 4'd0;
      #1;
      rst      = 1'b1;
      in_valid = 1'b1;
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk("post_rst_no_write", 32'(rf_wr_en), 32'd0);

      // zero result, arithmetic: write in N+1, ZERO flag from N+2
      step(1'b1, 19'h00000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("t1_wr_en", 32'(rf_wr_en),   32'd1);
      chk("t1_addr",  32'(rf_wr_addr), 32'd3);
      chk("t1_data",  32'(rf_wr_data), 32'd0);
      idle(1);
      chk("t1_flags", 32'(flags), 32'b0001);

      // logical op with carry/overflow asserted: only SIGN survives
      step(1'b1, 19'h40000, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("t2_flags", 32'(flags), 32'b0010);

      // three back-to-back pushes with the write port busy
      step(1'b1, 19'h00111, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 19'h00222, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 19'h00333, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_full", 32'(in_ready), 32'd0);
      step(1'b1, 19'h00333, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 19'h00333, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);

      // push and commit in the same cycle at one entry
      step(1'b1, 19'h0aaaa, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 19'h05555, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("t4_fwd_data", 32'(fwd_data), 32'h05555);
      idle(2);

      // flush with two entries and a simultaneous push
      step(1'b1, 19'h00000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 19'h7ffff, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 19'h12345, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
      chk("t5_fwd_valid", 32'(fwd_valid), 32'd0);
      chk("t5_flags",     32'(flags),     32'b0010);
      idle(1);

      // randomized traffic with one asynchronous reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset();
         case ($urandom_range(0, 3))
            0:       rres = 19'd0;
            1:       rres = 19'h40000 | 19'($urandom);
            default: rres = 19'($urandom);
         endcase
         step(($urandom_range(0, 9) < 6), rres, 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      end
      idle(4);

      @(negedge clk);
      #2;
      chk("drain_writes", 32'(exp_wr.size()), 32'd0);
      chk("drain_cycles", 32'(cyc_q.size()),  32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
